adder_128bit_slice_seq: RTL and testbench

//  Sequencer stage that wraps a registered 16-bit slice adder. Splits 128-bit operands into
//  16-bit slices and issues one slice per cycle to the adder (A/B/enable). Consumes the

---
 rtl/adder_128bit_slice_seq_if.sv | 67 ++++++
 rtl/adder_128bit_slice_seq.sv | 150 +++++++++++++++
 tb/tb_adder_128bit_slice_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_128bit_slice_seq_if.sv
// Bundle of operand, adder and result signals for adder_128bit_slice_seq.
// Optional feature macro: SEQ_ADD_CIN_EN adds the in_cin operand carry input.
// The slave modport is the sequencer. The master modport is its environment,
// which supplies operands, models the slice adder and consumes results.
interface adder_128bit_slice_seq_if #(
  parameter int WIDTH = 128,
  parameter int SLICE = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
`ifdef SEQ_ADD_CIN_EN
  logic             in_cin;
`endif

  logic [SLICE-1:0] adder_a;
  logic [SLICE-1:0] adder_b;
  logic             adder_en;
  logic [SLICE-1:0] adder_sum;
  logic             adder_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport slave (
    input  in_valid,
`ifdef SEQ_ADD_CIN_EN
    input  in_cin,
`endif
    input  in_a,
    input  in_b,
    output in_ready,
    output adder_a,
    output adder_b,
    output adder_en,
    input  adder_sum,
    input  adder_cout,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_cout
  );

  modport master (
    output in_valid,
`ifdef SEQ_ADD_CIN_EN
    output in_cin,
`endif
    output in_a,
    output in_b,
    input  in_ready,
    input  adder_a,
    input  adder_b,
    input  adder_en,
    output adder_sum,
    output adder_cout,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_cout
  );

endinterface

// File: rtl/adder_128bit_slice_seq.sv
// Slice sequencer around a registered SLICE-bit adder whose Cin is tied to 0.
// Operands are issued one slice per cycle, LSB slice first. Returned slices are
// carry-corrected here and assembled into the WIDTH-bit result.
// Optional feature macro: SEQ_ADD_CIN_EN seeds the carry chain from in_cin.
module adder_128bit_slice_seq #(
  parameter int WIDTH   = 128,
  parameter int SLICE   = 16,
  parameter int ADD_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  adder_128bit_slice_seq_if.slave      bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     ret_cnt;
  logic                 carry;
  logic [ADD_LAT-1:0]   valid_pipe;

  logic                 in_ready_r;
  logic                 adder_en_r;
  logic [SLICE-1:0]     adder_a_r;
  logic [SLICE-1:0]     adder_b_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_sum_r;
  logic                 out_cout_r;

  logic                 ret_strobe;
  logic                 ret_last;
  logic [SLICE-1:0]     ret_sum;
  logic                 ret_carry;

  // A slice is only trusted while an operation is in flight and the valid pipe
  // says this cycle's adder output belongs to one of our issued slices.
  assign ret_strobe = valid_pipe[ADD_LAT-1] && ((state == ISSUE) || (state == DRAIN));
  assign ret_last   = (ret_cnt == CNT_W'(N - 1));

  // The adder never sees our carry, so it is added on the return path. A carry
  // passes through a slice that summed to all ones even when the adder's own
  // Cout is 0.
  assign ret_sum   = bus.adder_sum + {{(SLICE-1){1'b0}}, carry};
  assign ret_carry = bus.adder_cout | (carry & (&bus.adder_sum));

  assign bus.in_ready  = in_ready_r;
  assign bus.adder_en  = adder_en_r;
  assign bus.adder_a   = adder_a_r;
  assign bus.adder_b   = adder_b_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_cout  = out_cout_r;

  // Control FSM, slice issue, valid pipe and result assembly share one block so
  // every output is registered and a reset drops everything in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      carry       <= 1'b0;
      valid_pipe  <= '0;
      in_ready_r  <= 1'b1;
      adder_en_r  <= 1'b0;
      adder_a_r   <= '0;
      adder_b_r   <= '0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_cout_r  <= 1'b0;
    end else begin
      valid_pipe <= ADD_LAT'({valid_pipe, adder_en_r});

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a       <= bus.in_a;
            op_b       <= bus.in_b;
`ifdef SEQ_ADD_CIN_EN
            carry      <= bus.in_cin;
`else
            carry      <= 1'b0;
`endif
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            out_sum_r  <= '0;
            out_cout_r <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          adder_en_r <= 1'b1;
          adder_a_r  <= op_a[issue_cnt*SLICE +: SLICE];
          adder_b_r  <= op_b[issue_cnt*SLICE +: SLICE];
          if (issue_cnt == CNT_W'(N - 1)) begin
            state <= DRAIN;
          end else begin
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
        end

        DRAIN: begin
          adder_en_r <= 1'b0;
          adder_a_r  <= '0;
          adder_b_r  <= '0;
          if (ret_strobe && ret_last) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (ret_strobe) begin
        out_sum_r[ret_cnt*SLICE +: SLICE] <= ret_sum;
        carry   <= ret_carry;
        ret_cnt <= ret_cnt + CNT_W'(1);
        if (ret_last) begin
          out_cout_r <= ret_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_128bit_slice_seq.sv
// Self-checking bench for adder_128bit_slice_seq.
// Optional feature macro: SEQ_ADD_CIN_EN enables the in_cin stimulus and checks.
// Results are compared against plain 129-bit arithmetic on the operands.
// The bench also models the external registered 16-bit adder (Cin tied to 0).
module tb_adder_128bit_slice_seq;

  localparam int WIDTH   = 128;
  localparam int SLICE   = 16;
  localparam int ADD_LAT = 2;
  localparam int N       = WIDTH / SLICE;
  localparam int EXP_LAT = N + ADD_LAT + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  adder_128bit_slice_seq_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

  adder_128bit_slice_seq #(
    .WIDTH  (WIDTH),
    .SLICE  (SLICE),
    .ADD_LAT(ADD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Two-stage registered slice adder: operands sampled on the first edge after
  // issue, result visible after the second. It holds its outputs when idle.
  logic [SLICE-1:0] stage_sum;
  logic             stage_cout;
  always @(posedge clk) begin
    if (bus.adder_en) begin
      {stage_cout, stage_sum} <= {1'b0, bus.adder_a} + {1'b0, bus.adder_b};
    end
    bus.adder_sum  <= stage_sum;
    bus.adder_cout <= stage_cout;
  end

  task automatic checkOutput(input string tag, input logic [128:0] observed,
                             input logic [128:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},  129'(bus.in_ready),  129'(1));
    checkOutput({tag, "_out_valid"}, 129'(bus.out_valid), 129'(0));
    checkOutput({tag, "_adder_en"},  129'(bus.adder_en),  129'(0));
    checkOutput({tag, "_adder_a"},   129'(bus.adder_a),   129'(0));
    checkOutput({tag, "_out_sum"},   129'(bus.out_sum),   129'(0));
    checkOutput({tag, "_out_cout"},  129'(bus.out_cout),  129'(0));
  endtask

  // One complete transaction, entered and left on a falling edge.
  task automatic applyStimulus(input string tag, input logic [127:0] a,
                               input logic [127:0] b, input logic cin,
                               input int hold);
    logic [128:0] expected;
    int cyc;
    int en_cnt;
    int en_first;
    int en_last;

    expected = {1'b0, a} + {1'b0, b} + 129'(cin);

    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_ready_before"}, 129'(bus.in_ready), 129'(1));

    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
`ifdef SEQ_ADD_CIN_EN
    bus.in_cin   = cin;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = rand128();
    bus.in_b     = rand128();
`ifdef SEQ_ADD_CIN_EN
    bus.in_cin   = 1'($urandom);
`endif
    checkOutput({tag, "_ready_busy"}, 129'(bus.in_ready), 129'(0));

    cyc      = 0;
    en_cnt   = 0;
    en_first = -1;
    en_last  = -1;
    while (!bus.out_valid && cyc < 100) begin
      if (bus.adder_en) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
      end
      bus.in_valid = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    checkOutput({tag, "_latency"},  129'(cyc),    129'(EXP_LAT));
    checkOutput({tag, "_en_count"}, 129'(en_cnt), 129'(N));
    checkOutput({tag, "_en_span"},  129'(en_last - en_first + 1), 129'(N));
    checkOutput({tag, "_sum"},  129'(bus.out_sum),  129'(expected[127:0]));
    checkOutput({tag, "_cout"}, 129'(bus.out_cout), 129'(expected[128]));

    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = rand128();
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 129'(bus.out_valid), 129'(1));
      checkOutput({tag, "_hold_sum"},   129'(bus.out_sum),   129'(expected[127:0]));
      checkOutput({tag, "_hold_ready"}, 129'(bus.in_ready),  129'(0));
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 129'(bus.out_valid), 129'(0));
    checkOutput({tag, "_ready_back"}, 129'(bus.in_ready),  129'(1));
  endtask

  // Hard stop in case a handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] pat_a;
    logic [127:0] pat_b;
    logic         cin;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
`ifdef SEQ_ADD_CIN_EN
    bus.in_cin    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    applyStimulus("one_plus_two", 128'd1, 128'd2, 1'b0, 0);
    applyStimulus("wrap", {128{1'b1}}, 128'd1, 1'b0, 1);

    for (int i = 0; i < 4; i++) begin
      pat_a[i*32 +: 32] = 32'h0000FFFF;
      pat_b[i*32 +: 32] = 32'h00000001;
    end
    applyStimulus("slice_ripple", pat_a, pat_b, 1'b0, 0);
    applyStimulus("backpressure", rand128(), rand128(), 1'b0, 5);

    // Reset while slice 4 is on the adder bus, then a fresh op.
    a = rand128();
    b = rand128();
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_en",     129'(bus.adder_en), 129'(1));
    checkOutput("midrst_slice4", 129'(bus.adder_a),  129'(a[4*SLICE +: SLICE]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("midrst");
    applyStimulus("after_rst", 128'd5, 128'd7, 1'b0, 0);

`ifdef SEQ_ADD_CIN_EN
    applyStimulus("cin_wrap", {128{1'b1}}, 128'd0, 1'b1, 0);
`endif

    for (int t = 0; t < 12; t++) begin
      a = rand128();
      case (t % 4)
        0: b = rand128();
        1: b = ~a;
        2: b = ~a + 128'd1;
        default: begin
          b = rand128();
          for (int s = 0; s < N; s++) begin
            if ($urandom_range(0, 1) == 1) a[s*SLICE +: SLICE] = ~b[s*SLICE +: SLICE];
          end
        end
      endcase
`ifdef SEQ_ADD_CIN_EN
      cin = 1'($urandom);
`else
      cin = 1'b0;
`endif
      applyStimulus("random", a, b, cin, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
